// File: rtl/ahb_master_req_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_master_req_ctrl
// Master-side AHB request controller. Takes one burst command from the local
// datapath, requests the bus, and once granted drives the address phase of
// every beat. It pulses done when the last data phase completes.
//
// Ports
//   hclk, hreset_n   clock, asynchronous active-low reset
//   cmd_valid/ready  command handshake (ready only while idle)
//   cmd_addr/burst/size/write  command payload (size clamped to MAX_SIZE)
//   hreq / hgrant    bus request to / grant from the arbiter
//   hwait            slave stall of the current phase
//   htrans/haddr/hburst/hsize/hwrite  AHB address-phase outputs
//   beat_cnt         index of the beat currently in address phase
//   done             one-cycle pulse when the final data phase completes
// ---------------------------------------------------------------------------
module ahb_master_req_ctrl #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned MAX_SIZE = 2
) (
   input  logic              hclk,
   input  logic              hreset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [2:0]        cmd_burst,
   input  logic [2:0]        cmd_size,
   input  logic              cmd_write,
   output logic              hreq,
   input  logic              hgrant,
   input  logic              hwait,
   output logic [1:0]        htrans,
   output logic [ADDR_W-1:0] haddr,
   output logic [2:0]        hburst,
   output logic [2:0]        hsize,
   output logic              hwrite,
   output logic [3:0]        beat_cnt,
   output logic              done
);

   localparam logic [1:0] TRANS_IDLE   = 2'd0;
   localparam logic [1:0] TRANS_NONSEQ = 2'd2;
   localparam logic [1:0] TRANS_SEQ    = 2'd3;
   localparam logic [2:0] SIZE_MAX     = 3'(MAX_SIZE);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_ADDR,
      ST_LAST
   } state_t;

   state_t            state;
   logic [3:0]        beats_m1;
   logic              wrap;
   logic              last_beat;
   logic [2:0]        size_clamped;
   logic [ADDR_W-1:0] step;
   logic [ADDR_W-1:0] wrap_mask;
   logic [ADDR_W-1:0] incr_addr;
   logic [ADDR_W-1:0] next_addr;

   // Beat count (minus one) and wrap flag decoded from the latched burst type
   always_comb begin
      beats_m1 = 4'd0;
      wrap     = 1'b0;
      case (hburst)
         3'd2:    begin beats_m1 = 4'd3;  wrap = 1'b1; end
         3'd3:    beats_m1 = 4'd3;
         3'd4:    begin beats_m1 = 4'd7;  wrap = 1'b1; end
         3'd5:    beats_m1 = 4'd7;
         3'd6:    begin beats_m1 = 4'd15; wrap = 1'b1; end
         3'd7:    beats_m1 = 4'd15;
         default: beats_m1 = 4'd0;
      endcase
   end

   // Next beat address; wrapping bursts keep the bits above the wrap window
   assign step         = ADDR_W'(1) << hsize;
   assign wrap_mask    = ((ADDR_W'(beats_m1) + ADDR_W'(1)) << hsize) - ADDR_W'(1);
   assign incr_addr    = haddr + step;
   assign next_addr    = wrap ? ((haddr & ~wrap_mask) | (incr_addr & wrap_mask)) : incr_addr;
   assign last_beat    = (beat_cnt == beats_m1);
   assign size_clamped = (cmd_size > SIZE_MAX) ? SIZE_MAX : cmd_size;

   // Control FSM with registered outputs
   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state     <= ST_IDLE;
         cmd_ready <= 1'b1;
         hreq      <= 1'b0;
         htrans    <= TRANS_IDLE;
         haddr     <= '0;
         hburst    <= 3'd0;
         hsize     <= 3'd0;
         hwrite    <= 1'b0;
         beat_cnt  <= 4'd0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               // Ready returns one cycle after done, so accept never overlaps it
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  hburst    <= cmd_burst;
                  hsize     <= size_clamped;
                  hwrite    <= cmd_write;
                  haddr     <= cmd_addr;
                  beat_cnt  <= 4'd0;
                  hreq      <= 1'b1;
                  state     <= ST_REQ;
               end
            end
            ST_REQ: begin
               hreq <= 1'b1;
               if (hgrant) begin
                  htrans <= TRANS_NONSEQ;
                  state  <= ST_ADDR;
               end else begin
                  htrans <= TRANS_IDLE;
               end
            end
            ST_ADDR: begin
               // hwait=1 holds every output; the beat completes on hwait=0
               if (!hwait) begin
                  if (last_beat) begin
                     hreq   <= 1'b0;
                     htrans <= TRANS_IDLE;
                     state  <= ST_LAST;
                  end else begin
                     beat_cnt <= beat_cnt + 4'd1;
                     haddr    <= next_addr;
                     if (hgrant) begin
                        htrans <= TRANS_SEQ;
                     end else begin
                        // Grant lost: re-request and resume with NONSEQ
                        htrans <= TRANS_IDLE;
                        state  <= ST_REQ;
                     end
                  end
               end
            end
            ST_LAST: begin
               if (!hwait) begin
                  done  <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_master_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ahb_master_req_ctrl
// Scoreboard bench: each command pushes its expected beats (htrans, haddr,
// beat_cnt); a negedge monitor pops one entry per accepted address phase.
// A per-command driver plays arbiter/slave (grant delay, stalls, grant loss).
// ---------------------------------------------------------------------------
module tb_ahb_master_req_ctrl;

   localparam int unsigned ADDR_W = 32;

   typedef struct packed {
      logic [1:0]  tr;
      logic [31:0] addr;
      logic [3:0]  beat;
   } beat_t;

   logic              hclk;
   logic              hreset_n;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic [2:0]        cmd_burst;
   logic [2:0]        cmd_size;
   logic              cmd_write;
   logic              hreq;
   logic              hgrant;
   logic              hwait;
   logic [1:0]        htrans;
   logic [ADDR_W-1:0] haddr;
   logic [2:0]        hburst;
   logic [2:0]        hsize;
   logic              hwrite;
   logic [3:0]        beat_cnt;
   logic              done;

   int    n_chk  = 0;
   int    n_pass = 0;
   beat_t exp_q[$];
   beat_t mon_e;

   ahb_master_req_ctrl #(.ADDR_W(ADDR_W), .MAX_SIZE(2)) dut (
      .hclk      (hclk),
      .hreset_n  (hreset_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_burst (cmd_burst),
      .cmd_size  (cmd_size),
      .cmd_write (cmd_write),
      .hreq      (hreq),
      .hgrant    (hgrant),
      .hwait     (hwait),
      .htrans    (htrans),
      .haddr     (haddr),
      .hburst    (hburst),
      .hsize     (hsize),
      .hwrite    (hwrite),
      .beat_cnt  (beat_cnt),
      .done      (done)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic int beats_of(input logic [2:0] b);
      case (b)
         3'd2, 3'd3: return 4;
         3'd4, 3'd5: return 8;
         3'd6, 3'd7: return 16;
         default:    return 1;
      endcase
   endfunction

   function automatic logic [31:0] model_next(input logic [31:0] a, input logic [2:0] b,
                                              input int sz);
      logic [31:0] st, total, base;
      st = 32'd1 << sz;
      if (b == 3'd2 || b == 3'd4 || b == 3'd6) begin
         total = 32'(beats_of(b)) * st;
         base  = a - (a % total);
         return base + ((a - base + st) % total);
      end
      return a + st;
   endfunction

   // Monitor: an address phase with hwait=0 completes at the next edge
   always @(negedge hclk) begin
      if (hreset_n && htrans != 2'd0 && !hwait) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'(haddr), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            mon_e = exp_q.pop_front();
            chk("htrans", 64'(htrans), 64'(mon_e.tr));
            chk("haddr", 64'(haddr), 64'(mon_e.addr));
            chk("beat_cnt", 64'(beat_cnt), 64'(mon_e.beat));
         end
      end
   end

   task automatic push_expected(input logic [31:0] addr, input logic [2:0] burst,
                                input int sz, input int drop_beat);
      beat_t e;
      logic [31:0] a;
      a = addr;
      for (int i = 0; i < beats_of(burst); i++) begin
         e.tr   = (i == 0 || i == drop_beat + 1) ? 2'd2 : 2'd3;
         e.addr = a;
         e.beat = 4'(i);
         exp_q.push_back(e);
         a = model_next(a, burst, sz);
      end
   endtask

   task automatic issue_cmd(input logic [31:0] addr, input logic [2:0] burst,
                            input logic [2:0] size, input logic wr);
      int n;
      int sz;
      sz = (size > 3'd2) ? 2 : int'(size);
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(posedge hclk); #1;
         n++;
      end
      chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
      cmd_addr  = addr;
      cmd_burst = burst;
      cmd_size  = size;
      cmd_write = wr;
      cmd_valid = 1'b1;
      @(posedge hclk); #1;
      cmd_valid = 1'b0;
      chk("hreq_after_accept", 64'(hreq), 64'd1);
      chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
      chk("htrans_req", 64'(htrans), 64'd0);
      chk("hburst_latch", 64'(hburst), 64'(burst));
      chk("hsize_latch", 64'(hsize), 64'(sz));
      chk("hwrite_latch", 64'(hwrite), 64'(wr));
   endtask

   // Full command: arbiter grant after grant_delay REQ cycles, optional stall
   // on one beat and optional grant loss during one beat
   task automatic run(input logic [31:0] addr, input logic [2:0] burst, input logic [2:0] size,
                      input logic wr, input int grant_delay, input int stall_beat,
                      input int stall_cycles, input int drop_beat);
      int k, acc_k, stall_left, gcnt, last;
      bit fin, dropped, prev_hwait;
      logic [31:0] s_addr;
      logic [1:0]  s_tr;
      logic [3:0]  s_beat;
      last       = beats_of(burst) - 1;
      push_expected(addr, burst, (size > 3'd2) ? 2 : int'(size), drop_beat);
      issue_cmd(addr, burst, size, wr);
      k = 0; acc_k = -100; stall_left = stall_cycles; gcnt = 0;
      fin = 0; dropped = 0; prev_hwait = 0;
      s_addr = '0; s_tr = '0; s_beat = '0;
      while (!fin && k < 300) begin
         if (k > 0) begin
            @(posedge hclk); #1;
         end
         k++;
         if (prev_hwait) begin
            chk("stall_haddr", 64'(haddr), 64'(s_addr));
            chk("stall_htrans", 64'(htrans), 64'(s_tr));
            chk("stall_beat", 64'(beat_cnt), 64'(s_beat));
         end
         if (k == acc_k + 1) chk("hreq_drop", 64'(hreq), 64'd0);
         if (done) begin
            chk("done_latency", 64'(k - acc_k), 64'd2);
            chk("ready_low_at_done", 64'(cmd_ready), 64'd0);
            fin = 1;
         end else begin
            if (htrans != 2'd0 && int'(beat_cnt) == stall_beat && stall_left > 0) begin
               hwait = 1'b1;
               stall_left--;
            end else begin
               hwait = 1'b0;
            end
            if (htrans != 2'd0 && int'(beat_cnt) == drop_beat && !dropped && !hwait) begin
               hgrant  = 1'b0;
               dropped = 1;
            end else if (hreq && htrans == 2'd0) begin
               hgrant = (gcnt >= grant_delay);
               gcnt++;
            end
            if (htrans != 2'd0 && !hwait && int'(beat_cnt) == last) acc_k = k;
            prev_hwait = hwait;
            s_addr = haddr; s_tr = htrans; s_beat = beat_cnt;
         end
      end
      hwait  = 1'b0;
      hgrant = 1'b0;
      if (!fin) begin
         chk("timeout_done", 64'd0, 64'd1);
      end else begin
         @(posedge hclk); #1;
         chk("done_one_cycle", 64'(done), 64'd0);
         chk("ready_after_done", 64'(cmd_ready), 64'd1);
      end
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
      chk({pfx, "_hreq"}, 64'(hreq), 64'd0);
      chk({pfx, "_htrans"}, 64'(htrans), 64'd0);
      chk({pfx, "_haddr"}, 64'(haddr), 64'd0);
      chk({pfx, "_hburst"}, 64'(hburst), 64'd0);
      chk({pfx, "_hsize"}, 64'(hsize), 64'd0);
      chk({pfx, "_hwrite"}, 64'(hwrite), 64'd0);
      chk({pfx, "_beat_cnt"}, 64'(beat_cnt), 64'd0);
      chk({pfx, "_done"}, 64'(done), 64'd0);
   endtask

   initial begin
      hreset_n  = 1'b0;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_burst = 3'd0;
      cmd_size  = 3'd0;
      cmd_write = 1'b0;
      hgrant    = 1'b0;
      hwait     = 1'b0;
      repeat (3) @(posedge hclk);
      #1;
      chk_reset_vals("rst");
      hreset_n = 1'b1;
      @(posedge hclk); #1;

      // SINGLE write, grant two cycles after hreq
      run(32'h100, 3'd0, 3'd2, 1'b1, 2, -1, 0, -1);
      // INCR4 read
      run(32'h200, 3'd3, 3'd2, 1'b0, 0, -1, 0, -1);
      // WRAP4 from 0x38
      run(32'h38, 3'd2, 3'd2, 1'b0, 1, -1, 0, -1);
      // WRAP8 from 0x1E, halfword
      run(32'h1E, 3'd4, 3'd1, 1'b1, 0, -1, 0, -1);
      // INCR8 with 3 wait cycles on beat 2
      run(32'h300, 3'd5, 3'd2, 1'b1, 0, 2, 3, -1);
      // INCR4 losing grant after beat 1
      run(32'h500, 3'd3, 3'd2, 1'b0, 0, -1, 0, 1);
      // Oversized cmd_size clamps to word
      run(32'h400, 3'd3, 3'd3, 1'b1, 0, -1, 0, -1);
      // INCR16 with grant delay
      run(32'h600, 3'd7, 3'd2, 1'b0, 3, -1, 0, -1);

      // Reset asserted in the middle of a WRAP16
      push_expected(32'h48, 3'd6, 2, -1);
      issue_cmd(32'h48, 3'd6, 3'd2, 1'b1);
      hgrant = 1'b1;
      repeat (6) @(posedge hclk);
      #1;
      chk("mid_burst_active", 64'(htrans != 2'd0), 64'd1);
      #2;
      hreset_n = 1'b0;
      #1;
      chk_reset_vals("abort");
      exp_q.delete();
      hgrant = 1'b0;
      repeat (2) @(posedge hclk);
      #1;
      hreset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge hclk); #1;
         chk("no_done_after_abort", 64'(done), 64'd0);
      end

      // Recovery after reset
      run(32'h700, 3'd3, 3'd2, 1'b1, 0, -1, 0, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
